// File: rtl/gp_register_file.sv
// General-purpose register file: two combinational read ports, one synchronous write port,
// optional write-to-read bypass and a per-register busy scoreboard for pending destinations.
module gp_register_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [AW-1:0]                rd_a_addr,
  output logic [DATA_W-1:0]            rd_a_data,
  output logic                         rd_a_ready,
  input  logic [AW-1:0]                rd_b_addr,
  output logic [DATA_W-1:0]            rd_b_data,
  output logic                         rd_b_ready,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  output logic                         rsv_grant,
  output logic [NUM_REGS-1:0]          busy_mask,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  logic wr_zero, rsv_zero, a_zero, b_zero;
  logic wr_live, a_hit, b_hit;

  // A hard-wired zero register swallows writes and reservations and always reads as a ready 0.
  assign wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
  assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
  assign a_zero   = (ZERO_REG != 0) && (rd_a_addr == '0);
  assign b_zero   = (ZERO_REG != 0) && (rd_b_addr == '0);

  assign wr_live  = wr_en && !wr_zero;
  assign a_hit    = (BYPASS != 0) && wr_live && (wr_addr == rd_a_addr);
  assign b_hit    = (BYPASS != 0) && wr_live && (wr_addr == rd_b_addr);

  assign rd_a_data  = a_zero ? '0 : (a_hit ? wr_data : regs[rd_a_addr]);
  assign rd_b_data  = b_zero ? '0 : (b_hit ? wr_data : regs[rd_b_addr]);
  assign rd_a_ready = a_zero || !busy[rd_a_addr] || a_hit;
  assign rd_b_ready = b_zero || !busy[rd_b_addr] || b_hit;

  // A busy register can be re-reserved only when its writeback lands in the same cycle.
  assign rsv_grant = rsv_en &&
                     (rsv_zero || !busy[rsv_addr] || (wr_live && (wr_addr == rsv_addr)));

  // Release first, then reserve, so a same-address write+reserve leaves the register busy.
  always_comb begin
    busy_next = busy;
    if (wr_live)
      busy_next[wr_addr] = 1'b0;
    if (rsv_grant && !rsv_zero)
      busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      busy <= busy_next;
      if (wr_live)
        regs[wr_addr] <= wr_data;
    end
  end

  assign busy_mask = busy;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end

endmodule

// File: tb/tb_gp_register_file.sv
// Bench for gp_register_file: a default 4x16 bypassing instance driven by vectors and random
// traffic against an array model, plus a 16x32 zero-register, non-bypassing instance.
module tb_gp_register_file;

  logic clk = 1'b0;
  logic reset;

  logic        wr_en, rsv_en;
  logic [1:0]  wr_addr, rd_a_addr, rd_b_addr, rsv_addr;
  logic [15:0] wr_data, rd_a_data, rd_b_data;
  logic        rd_a_ready, rd_b_ready, rsv_grant;
  logic [3:0]  busy_mask;
  logic [63:0] regs_flat;

  logic         z_wr_en, z_rsv_en;
  logic [3:0]   z_wr_addr, z_rd_a_addr, z_rd_b_addr, z_rsv_addr;
  logic [31:0]  z_wr_data, z_rd_a_data, z_rd_b_data;
  logic         z_rd_a_ready, z_rd_b_ready, z_rsv_grant;
  logic [15:0]  z_busy_mask;
  logic [511:0] z_regs_flat;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [4];
  bit          m_busy [4];

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        re;
    logic [1:0]  ra;
    logic [15:0] exp_a;
    logic        exp_a_rdy;
    logic [15:0] exp_b;
    logic        exp_b_rdy;
    logic        exp_grant;
    logic [3:0]  exp_busy;
  } vec_t;

  vec_t vecs [9];

  gp_register_file dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .rd_a_ready(rd_a_ready),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data), .rd_b_ready(rd_b_ready),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_grant(rsv_grant),
    .busy_mask(busy_mask), .regs_flat(regs_flat)
  );

  gp_register_file #(.DATA_W(32), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(0)) dut_z (
    .clk(clk), .reset(reset),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .rd_a_addr(z_rd_a_addr), .rd_a_data(z_rd_a_data), .rd_a_ready(z_rd_a_ready),
    .rd_b_addr(z_rd_b_addr), .rd_b_data(z_rd_b_data), .rd_b_ready(z_rd_b_ready),
    .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr), .rsv_grant(z_rsv_grant),
    .busy_mask(z_busy_mask), .regs_flat(z_regs_flat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                               input logic [1:0] a, input logic [1:0] b,
                               input logic re, input logic [1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_a_addr = a; rd_b_addr = b; rsv_en = re; rsv_addr = ra;
  endtask

  task automatic zDrive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic re, input logic [3:0] ra);
    z_wr_en = we; z_wr_addr = wa; z_wr_data = wd;
    z_rd_a_addr = a; z_rd_b_addr = b; z_rsv_en = re; z_rsv_addr = ra;
  endtask

  // The reference model works straight from the architectural rules: a write is visible to a
  // matching reader at once, a busy reader is not ready, and a reservation needs a free target.
  task automatic checkModelComb();
    bit hit_a, hit_b, hit_r, grant;
    hit_a = wr_en && (wr_addr == rd_a_addr);
    hit_b = wr_en && (wr_addr == rd_b_addr);
    hit_r = wr_en && (wr_addr == rsv_addr);
    grant = rsv_en && (!m_busy[rsv_addr] || hit_r);
    checkOutput("rnd_rd_a_data", 64'(rd_a_data), 64'(hit_a ? wr_data : m_regs[rd_a_addr]));
    checkOutput("rnd_rd_b_data", 64'(rd_b_data), 64'(hit_b ? wr_data : m_regs[rd_b_addr]));
    checkOutput("rnd_rd_a_ready", 64'(rd_a_ready), 64'(!m_busy[rd_a_addr] || hit_a));
    checkOutput("rnd_rd_b_ready", 64'(rd_b_ready), 64'(!m_busy[rd_b_addr] || hit_b));
    checkOutput("rnd_rsv_grant", 64'(rsv_grant), 64'(grant));
  endtask

  task automatic stepModel();
    bit grant;
    grant = rsv_en && (!m_busy[rsv_addr] || (wr_en && wr_addr == rsv_addr));
    if (wr_en) begin
      m_regs[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (grant)
      m_busy[rsv_addr] = 1'b1;
  endtask

  task automatic checkModelState(input string tag);
    logic [3:0]  eb;
    logic [63:0] ef;
    for (int i = 0; i < 4; i++) begin
      eb[i] = m_busy[i];
      ef[i*16 +: 16] = m_regs[i];
    end
    checkOutput({tag, "_busy_mask"}, 64'(busy_mask), 64'(eb));
    checkOutput({tag, "_regs_flat"}, regs_flat, ef);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 4; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] v;

    vecs[0] = '{1'b1, 2'd2, 16'hBEEF, 2'd2, 2'd0, 1'b0, 2'd0, 16'hBEEF, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b0000};
    vecs[1] = '{1'b0, 2'd0, 16'h0000, 2'd2, 2'd3, 1'b1, 2'd3, 16'hBEEF, 1'b1, 16'h0000, 1'b1, 1'b1, 4'b1000};
    vecs[2] = '{1'b0, 2'd0, 16'h0000, 2'd3, 2'd3, 1'b1, 2'd3, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b1000};
    vecs[3] = '{1'b1, 2'd3, 16'h0012, 2'd3, 2'd2, 1'b0, 2'd0, 16'h0012, 1'b1, 16'hBEEF, 1'b1, 1'b0, 4'b0000};
    vecs[4] = '{1'b0, 2'd0, 16'h0000, 2'd1, 2'd3, 1'b1, 2'd1, 16'h0000, 1'b1, 16'h0012, 1'b1, 1'b1, 4'b0010};
    vecs[5] = '{1'b1, 2'd1, 16'h00AA, 2'd1, 2'd1, 1'b1, 2'd1, 16'h00AA, 1'b1, 16'h00AA, 1'b1, 1'b1, 4'b0010};
    vecs[6] = '{1'b0, 2'd0, 16'h0000, 2'd1, 2'd2, 1'b0, 2'd0, 16'h00AA, 1'b0, 16'hBEEF, 1'b1, 1'b0, 4'b0010};
    vecs[7] = '{1'b1, 2'd0, 16'h1234, 2'd0, 2'd2, 1'b1, 2'd2, 16'h1234, 1'b1, 16'hBEEF, 1'b1, 1'b1, 4'b0110};
    vecs[8] = '{1'b0, 2'd0, 16'h0000, 2'd0, 2'd2, 1'b0, 2'd0, 16'h1234, 1'b1, 16'hBEEF, 1'b0, 1'b0, 4'b0110};

    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, 16'h0, 2'd1, 2'd3, 1'b0, 2'd0);
    zDrive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 4'd0);
    clearModel();
    #2;
    checkOutput("reset_regs_flat", regs_flat, 64'h0);
    checkOutput("reset_busy_mask", 64'(busy_mask), 64'h0);
    checkOutput("reset_rd_a_ready", 64'(rd_a_ready), 64'h1);
    checkOutput("reset_rd_b_data", 64'(rd_b_data), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a, vecs[i].b, vecs[i].re, vecs[i].ra);
      #1;
      checkOutput($sformatf("vec%0d_rd_a_data", i), 64'(rd_a_data), 64'(vecs[i].exp_a));
      checkOutput($sformatf("vec%0d_rd_a_ready", i), 64'(rd_a_ready), 64'(vecs[i].exp_a_rdy));
      checkOutput($sformatf("vec%0d_rd_b_data", i), 64'(rd_b_data), 64'(vecs[i].exp_b));
      checkOutput($sformatf("vec%0d_rd_b_ready", i), 64'(rd_b_ready), 64'(vecs[i].exp_b_rdy));
      checkOutput($sformatf("vec%0d_rsv_grant", i), 64'(rsv_grant), 64'(vecs[i].exp_grant));
      stepModel();
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_busy_mask", i), 64'(busy_mask), 64'(vecs[i].exp_busy));
      @(negedge clk);
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)), 16'($urandom),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)));
      #1;
      checkModelComb();
      stepModel();
      @(posedge clk);
      #1;
      checkModelState("rnd");
      @(negedge clk);
    end

    // Asynchronous reset while registers hold data and a reservation is pending.
    applyStimulus(1'b1, 2'd1, 16'h5A5A, 2'd2, 2'd1, 1'b1, 2'd2);
    #1;
    stepModel();
    @(posedge clk);
    #1;
    checkModelState("prerst");
    applyStimulus(1'b0, 2'd0, 16'h0, 2'd2, 2'd1, 1'b0, 2'd0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_regs_flat", regs_flat, 64'h0);
    checkOutput("midrst_busy_mask", 64'(busy_mask), 64'h0);
    checkOutput("midrst_rd_a_ready", 64'(rd_a_ready), 64'h1);
    clearModel();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 16'h0, 2'd2, 2'd1, 1'b1, 2'd2);
    #1;
    checkOutput("postrst_rsv_grant", 64'(rsv_grant), 64'h1);
    stepModel();
    @(posedge clk);
    #1;
    checkModelState("postrst");
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 16'h0, 2'd0, 2'd0, 1'b0, 2'd0);

    // Non-bypassing instance: same-cycle read sees the old value.
    zDrive(1'b1, 4'd2, 32'h0000BEEF, 4'd2, 4'd2, 1'b0, 4'd0);
    #1;
    checkOutput("z_nobyp_old_data", 64'(z_rd_a_data), 64'h0);
    checkOutput("z_nobyp_ready", 64'(z_rd_a_ready), 64'h1);
    @(posedge clk);
    #1;
    checkOutput("z_nobyp_new_data", 64'(z_rd_a_data), 64'h0000BEEF);
    @(negedge clk);

    zDrive(1'b1, 4'd0, 32'hFFFFFFFF, 4'd0, 4'd0, 1'b1, 4'd0);
    #1;
    checkOutput("z_r0_grant", 64'(z_rsv_grant), 64'h1);
    checkOutput("z_r0_data", 64'(z_rd_a_data), 64'h0);
    checkOutput("z_r0_ready", 64'(z_rd_a_ready), 64'h1);
    @(posedge clk);
    #1;
    checkOutput("z_r0_busy_mask", 64'(z_busy_mask), 64'h0);
    checkOutput("z_r0_after_data", 64'(z_rd_a_data), 64'h0);
    checkOutput("z_r0_flat", 64'(z_regs_flat[31:0]), 64'h0);
    @(negedge clk);

    zDrive(1'b0, 4'd0, 32'h0, 4'd5, 4'd5, 1'b1, 4'd5);
    #1;
    checkOutput("z_r5_grant", 64'(z_rsv_grant), 64'h1);
    @(posedge clk);
    #1;
    checkOutput("z_r5_busy_mask", 64'(z_busy_mask), 64'h0020);
    @(negedge clk);
    zDrive(1'b1, 4'd5, 32'h00000055, 4'd5, 4'd5, 1'b0, 4'd0);
    #1;
    checkOutput("z_r5_wb_ready", 64'(z_rd_a_ready), 64'h0);
    checkOutput("z_r5_wb_data", 64'(z_rd_b_data), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("z_r5_after_ready", 64'(z_rd_a_ready), 64'h1);
    checkOutput("z_r5_after_data", 64'(z_rd_a_data), 64'h00000055);
    checkOutput("z_r5_after_busy", 64'(z_busy_mask), 64'h0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      zDrive(1'b1, 4'(i), 32'h01010101 * 32'(i), 4'd0, 4'd0, 1'b0, 4'd0);
      @(posedge clk);
      @(negedge clk);
    end
    zDrive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      z_rd_a_addr = 4'(i);
      z_rd_b_addr = 4'(15 - i);
      #1;
      v = (i == 0) ? 32'h0 : 32'h01010101 * 32'(i);
      checkOutput($sformatf("z_fill_a%0d", i), 64'(z_rd_a_data), 64'(v));
      checkOutput($sformatf("z_fill_flat%0d", i), 64'(z_regs_flat[i*32 +: 32]), 64'(v));
      v = (i == 15) ? 32'h0 : 32'h01010101 * 32'(15 - i);
      checkOutput($sformatf("z_fill_b%0d", 15 - i), 64'(z_rd_b_data), 64'(v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
